// File: rtl/oob_device_responder.sv
// Device-side SATA OOB responder: answers COMRESET with COMINIT, COMWAKE with COMWAKE,
// then trains ALIGN/SYNC with the host and passes link-layer data through once linked.
module oob_device_responder #(
  parameter int unsigned COMINIT_LEN_G1 = 81,
  parameter int unsigned COMWAKE_LEN_G1 = 78,
  parameter int unsigned GAP_LEN        = 32,
  parameter int unsigned WAIT_TIMEOUT   = 132013,
  parameter int unsigned ALIGN_TIMEOUT  = 8192,
  parameter int unsigned SYNC_STABLE    = 51
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  gen,
  input  logic        rx_locked,
  input  logic        gt0_txresetdone_i,
  input  logic        gt0_rxresetdone_i,
  input  logic        cominitdet,
  input  logic        comwakedet,
  input  logic        rxbyteisaligned,
  input  logic [31:0] rx_datain,
  input  logic [3:0]  rx_charisk,
  input  logic [31:0] tx_datain,
  input  logic        tx_chariskin,
  output logic        txcominit,
  output logic        txcomwake,
  output logic        txelecidle,
  output logic [31:0] tx_dataout,
  output logic        tx_charisk_out,
  output logic [31:0] rx_dataout,
  output logic [3:0]  rx_charisk_out,
  output logic        linkup,
  output logic [3:0]  CurrentState_out
);

  typedef enum logic [3:0] {
    IDLE            = 4'd1,
    COMRESET_GAP    = 4'd2,
    SEND_COMINIT    = 4'd3,
    WAIT_COMWAKE    = 4'd4,
    SEND_COMWAKE    = 4'd5,
    WAIT_HOST_ALIGN = 4'd6,
    SEND_SYNC       = 4'd7,
    LINK_READY      = 4'd8
  } state_t;

  localparam int unsigned CNT_W = 18;
  localparam int unsigned SC_W  = $clog2(SYNC_STABLE) + 1;

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_TIMEOUT);
  localparam logic [SC_W-1:0]  SYNC_LAST  = SC_W'(SYNC_STABLE - 1);

  localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_P  = 32'hB5B5957C;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [31:0]       rx_data_q;
  logic [3:0]        rx_k_q;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              tx_k_q, tx_k_d;
  logic              linkup_q, linkup_d;

  logic [1:0]        eff_gen;
  logic [CNT_W-1:0]  cominit_last, comwake_last;
  logic              gtx_ready, align_det, sync_word;

  // gen=11 runs at gen3 burst lengths
  always_comb begin
    eff_gen      = gen[1] ? 2'd2 : gen;
    cominit_last = (CNT_W'(COMINIT_LEN_G1) << eff_gen) - CNT_W'(1);
    comwake_last = (CNT_W'(COMWAKE_LEN_G1) << eff_gen) - CNT_W'(1);
    gtx_ready    = rx_locked & gt0_txresetdone_i & gt0_rxresetdone_i;
    align_det    = (rx_data_q == ALIGN_P) & rx_k_q[0] & rxbyteisaligned;
    sync_word    = (rx_data_q == SYNC_P) & rx_k_q[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      sync_cnt_q <= '0;
      rx_data_q  <= '0;
      rx_k_q     <= '0;
      tx_data_q  <= '0;
      tx_k_q     <= 1'b0;
      linkup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sync_cnt_q <= sync_cnt_d;
      rx_data_q  <= rx_datain;
      rx_k_q     <= rx_charisk;
      tx_data_q  <= tx_data_d;
      tx_k_q     <= tx_k_d;
      linkup_q   <= linkup_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: ;
      COMRESET_GAP:
        if (count_q == GAP_LAST && gtx_ready) state_d = SEND_COMINIT;
      SEND_COMINIT:
        if (count_q == cominit_last) state_d = WAIT_COMWAKE;
      WAIT_COMWAKE:
        if (comwakedet)                  state_d = SEND_COMWAKE;
        else if (count_q == WAIT_LAST)   state_d = SEND_COMINIT;
      SEND_COMWAKE:
        if (count_q == comwake_last) state_d = WAIT_HOST_ALIGN;
      WAIT_HOST_ALIGN:
        if (align_det)                   state_d = SEND_SYNC;
        else if (count_q == ALIGN_LAST)  state_d = SEND_COMINIT;
      SEND_SYNC:
        if (sync_word && sync_cnt_q == SYNC_LAST) state_d = LINK_READY;
        else if (count_q == WAIT_LAST)            state_d = IDLE;
      LINK_READY: ;
      default: state_d = IDLE;
    endcase
    if (cominitdet) state_d = COMRESET_GAP;

    // cominitdet clears the count even when the state itself does not change
    count_d = count_q + CNT_W'(1);
    if (cominitdet || state_d != state_q) begin
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, LINK_READY: count_d = count_q;
        COMRESET_GAP:     if (count_q == GAP_LAST) count_d = count_q;
        default: ;
      endcase
    end

    sync_cnt_d = (state_q == SEND_SYNC && sync_word) ? sync_cnt_q + SC_W'(1) : '0;
  end

  always_comb begin
    txcominit  = (state_q == SEND_COMINIT);
    txcomwake  = (state_q == SEND_COMWAKE);
    txelecidle = !(state_q == WAIT_HOST_ALIGN || state_q == SEND_SYNC ||
                   state_q == LINK_READY);
    linkup_d   = (state_q == LINK_READY);
    tx_data_d  = ALIGN_P;
    tx_k_d     = 1'b1;
    case (state_q)
      SEND_SYNC: tx_data_d = SYNC_P;
      LINK_READY: begin
        tx_data_d = tx_datain;
        tx_k_d    = tx_chariskin;
      end
      default: ;
    endcase
  end

  assign tx_dataout       = tx_data_q;
  assign tx_charisk_out   = tx_k_q;
  assign rx_dataout       = rx_data_q;
  assign rx_charisk_out   = rx_k_q;
  assign linkup           = linkup_q;
  assign CurrentState_out = state_q;

endmodule

// File: tb/tb_oob_device_responder.sv
// Directed bench for oob_device_responder: burst lengths per gen, ALIGN/SYNC training,
// timeouts, passthrough in LINK_READY and reset/cominitdet recovery.
module tb_oob_device_responder;

  localparam int WT = 1000;
  localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_W  = 32'hB5B5957C;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  gen;
  logic        rx_locked, gt0_txresetdone_i, gt0_rxresetdone_i;
  logic        cominitdet, comwakedet, rxbyteisaligned;
  logic [31:0] rx_datain;
  logic [3:0]  rx_charisk;
  logic [31:0] tx_datain;
  logic        tx_chariskin;
  logic        txcominit, txcomwake, txelecidle;
  logic [31:0] tx_dataout;
  logic        tx_charisk_out;
  logic [31:0] rx_dataout;
  logic [3:0]  rx_charisk_out;
  logic        linkup;
  logic [3:0]  CurrentState_out;

  int total = 0;
  int bad   = 0;

  oob_device_responder #(
    .WAIT_TIMEOUT(WT)
  ) dut (
    .clk(clk), .reset(reset), .gen(gen), .rx_locked(rx_locked),
    .gt0_txresetdone_i(gt0_txresetdone_i), .gt0_rxresetdone_i(gt0_rxresetdone_i),
    .cominitdet(cominitdet), .comwakedet(comwakedet), .rxbyteisaligned(rxbyteisaligned),
    .rx_datain(rx_datain), .rx_charisk(rx_charisk), .tx_datain(tx_datain),
    .tx_chariskin(tx_chariskin), .txcominit(txcominit), .txcomwake(txcomwake),
    .txelecidle(txelecidle), .tx_dataout(tx_dataout), .tx_charisk_out(tx_charisk_out),
    .rx_dataout(rx_dataout), .rx_charisk_out(rx_charisk_out), .linkup(linkup),
    .CurrentState_out(CurrentState_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] g;
    int         cominit_len;
    int         comwake_len;
  } gen_vec_t;

  typedef struct {
    logic [31:0] txd;
    logic        txk;
    logic [31:0] rxd;
    logic [3:0]  rxk;
    logic [31:0] exp_txd;
    logic        exp_txk;
    logic [31:0] exp_rxd;
    logic [3:0]  exp_rxk;
  } pt_vec_t;

  gen_vec_t gv[4];
  pt_vec_t  pv[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int limit, output int n);
    n = 0;
    while (CurrentState_out != st && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " state"},      32'(CurrentState_out), 32'd1);
    check({tag, " txcominit"},  32'(txcominit), 32'd0);
    check({tag, " txcomwake"},  32'(txcomwake), 32'd0);
    check({tag, " txelecidle"}, 32'(txelecidle), 32'd1);
    check({tag, " tx_dataout"}, tx_dataout, 32'd0);
    check({tag, " tx_k"},       32'(tx_charisk_out), 32'd0);
    check({tag, " rx_dataout"}, rx_dataout, 32'd0);
    check({tag, " rx_k"},       32'(rx_charisk_out), 32'd0);
    check({tag, " linkup"},     32'(linkup), 32'd0);
  endtask

  task automatic pulse_cominit();
    cominitdet = 1'b1;
    tick();
    cominitdet = 1'b0;
  endtask

  task automatic pulse_comwake();
    comwakedet = 1'b1;
    tick();
    comwakedet = 1'b0;
  endtask

  // from any state: cominitdet, gap, COMINIT burst; ends on first WAIT_COMWAKE cycle
  task automatic bring_up(input logic [1:0] g, input int exp_len);
    int n;
    gen = g;
    pulse_cominit();
    wait_state(4'd3, 200, n);
    check("gap length", n, 32);
    check("txcominit high", 32'(txcominit), 32'd1);
    wait_state(4'd4, 2000, n);
    check("cominit length", n, exp_len);
    check("txcominit low after burst", 32'(txcominit), 32'd0);
  endtask

  task automatic comwake_to_align(input int exp_len);
    int n;
    pulse_comwake();
    check("txcomwake high", 32'(txcomwake), 32'd1);
    wait_state(4'd6, 2000, n);
    check("comwake length", n, exp_len);
    check("txelecidle in align", 32'(txelecidle), 32'd0);
    check("tx align word", tx_dataout, ALIGN_W);
    check("tx align k", 32'(tx_charisk_out), 32'd1);
  endtask

  task automatic host_align();
    int n;
    rx_datain = ALIGN_W;
    rx_charisk = 4'b0001;
    rxbyteisaligned = 1'b1;
    wait_state(4'd7, 20, n);
    check("align detect latency", n, 2);
  endtask

  initial begin
    int n;
    reset = 1'b1; gen = 2'b10;
    rx_locked = 1'b1; gt0_txresetdone_i = 1'b1; gt0_rxresetdone_i = 1'b1;
    cominitdet = 1'b0; comwakedet = 1'b0; rxbyteisaligned = 1'b0;
    rx_datain = '0; rx_charisk = '0; tx_datain = '0; tx_chariskin = 1'b0;

    gv[0] = '{2'b00, 81, 78};
    gv[1] = '{2'b01, 162, 156};
    gv[2] = '{2'b10, 324, 312};
    gv[3] = '{2'b11, 324, 312};

    pv[0] = '{32'hDEADBEEF, 1'b0, 32'h01234567, 4'h0, 32'hDEADBEEF, 1'b0, 32'h01234567, 4'h0};
    pv[1] = '{32'h00000000, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'hF};
    pv[2] = '{32'hA5A55A5A, 1'b0, 32'h7B4A4ABC, 4'h1, 32'hA5A55A5A, 1'b0, 32'h7B4A4ABC, 4'h1};
    pv[3] = '{32'h5A5AA5A5, 1'b1, 32'hB5B5957C, 4'h2, 32'h5A5AA5A5, 1'b1, 32'hB5B5957C, 4'h2};

    do_reset();
    check_reset_vals("reset");

    // burst lengths for every gen setting
    for (int i = 0; i < 4; i++) begin
      do_reset();
      rxbyteisaligned = 1'b0; rx_datain = '0; rx_charisk = '0;
      bring_up(gv[i].g, gv[i].cominit_len);
      check("state after cominit", 32'(CurrentState_out), 32'd4);
      comwake_to_align(gv[i].comwake_len);
    end

    // 51 consecutive SYNCs -> LINK_READY
    host_align();
    for (int i = 1; i <= 51; i++) begin
      rx_datain = SYNC_W; rx_charisk = 4'b0001;
      tick();
      if (i == 1) check("tx sync word", tx_dataout, SYNC_W);
    end
    check("state before link", 32'(CurrentState_out), 32'd7);
    check("linkup before link", 32'(linkup), 32'd0);
    tick();
    check("state link ready", 32'(CurrentState_out), 32'd8);
    check("linkup lag", 32'(linkup), 32'd0);
    tick();
    check("linkup asserted", 32'(linkup), 32'd1);

    for (int i = 0; i < 4; i++) begin
      tx_datain = pv[i].txd; tx_chariskin = pv[i].txk;
      rx_datain = pv[i].rxd; rx_charisk = pv[i].rxk;
      tick();
      check("pass tx data", tx_dataout, pv[i].exp_txd);
      check("pass tx k", 32'(tx_charisk_out), 32'(pv[i].exp_txk));
      check("pass rx data", rx_dataout, pv[i].exp_rxd);
      check("pass rx k", 32'(rx_charisk_out), 32'(pv[i].exp_rxk));
    end

    // cominitdet while linked
    pulse_cominit();
    check("relink state", 32'(CurrentState_out), 32'd2);
    check("relink elecidle", 32'(txelecidle), 32'd1);
    check("linkup still registered", 32'(linkup), 32'd1);
    tick();
    check("linkup dropped", 32'(linkup), 32'd0);
    check("tx back to align", tx_dataout, ALIGN_W);

    // broken SYNC run restarts the stability count
    do_reset();
    rxbyteisaligned = 1'b0; rx_datain = '0;
    bring_up(2'b00, 81);
    comwake_to_align(78);
    host_align();
    for (int i = 1; i <= 91; i++) begin
      rx_datain  = (i == 41) ? 32'h12345678 : SYNC_W;
      rx_charisk = (i == 41) ? 4'b0000 : 4'b0001;
      tick();
      if (i == 52) check("no link after broken run", 32'(CurrentState_out), 32'd7);
    end
    rx_datain = SYNC_W; rx_charisk = 4'b0001;
    tick();
    check("still syncing", 32'(CurrentState_out), 32'd7);
    tick();
    check("link after new run", 32'(CurrentState_out), 32'd8);
    tick();
    check("linkup after new run", 32'(linkup), 32'd1);

    // timeouts at gen1
    do_reset();
    rxbyteisaligned = 1'b0; rx_datain = '0; rx_charisk = '0;
    bring_up(2'b00, 81);
    wait_state(4'd3, 2000, n);
    check("comwake timeout", n, WT + 1);
    wait_state(4'd4, 200, n);
    check("retry cominit length", n, 81);
    repeat (WT) tick();
    check("wait at timeout edge", 32'(CurrentState_out), 32'd4);
    pulse_comwake();
    check("comwake beats timeout", 32'(CurrentState_out), 32'd5);
    wait_state(4'd6, 200, n);
    check("comwake len gen1", n, 78);
    rx_datain = ALIGN_W; rx_charisk = 4'b0001; rxbyteisaligned = 1'b0;
    wait_state(4'd3, 9000, n);
    check("align timeout", n, 8193);
    rx_datain = '0; rx_charisk = '0;
    wait_state(4'd4, 200, n);
    check("cominit after align timeout", n, 81);
    comwake_to_align(78);
    host_align();
    rx_datain = '0; rx_charisk = '0;
    wait_state(4'd1, 2000, n);
    check("sync timeout to idle", n, WT + 1);
    check("idle elecidle", 32'(txelecidle), 32'd1);

    // gap holds until GTX ready, and a second cominitdet restarts it
    do_reset();
    rx_locked = 1'b0;
    pulse_cominit();
    repeat (60) tick();
    check("gap hold not ready", 32'(CurrentState_out), 32'd2);
    rx_locked = 1'b1;
    tick();
    check("gap exit when ready", 32'(txcominit), 32'd1);
    do_reset();
    pulse_cominit();
    repeat (10) tick();
    pulse_cominit();
    wait_state(4'd3, 200, n);
    check("gap restart", n, 32);

    // reset during COMWAKE
    do_reset();
    bring_up(2'b01, 162);
    pulse_comwake();
    repeat (10) tick();
    rx_datain = 32'hCAFEF00D; rx_charisk = 4'hF;
    tick();
    check("rx delay", rx_dataout, 32'hCAFEF00D);
    check("mid comwake", 32'(txcomwake), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_vals("mid reset");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
